dmem_responder: RTL and testbench

Data-memory responder for the 32-bit RISC-V core: the memory-side endpoint of the MEM stage's data-memory interface. It accepts one load or store request at a time, applies a configurable number of wait states, performs byte/half/word access with lane selection and load sign/zero extension, and returns `read_data` with a one-cycle `ready` pulse. It sits between the MEM stage outputs (`address`, `w_data`) and the MEM stage `read_data` input.

---
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Data-memory request/response bundle between the MEM stage (master) and the
// data-memory responder (slave).
//   req           master->slave  request strobe
//   we            master->slave  1 = store, 0 = load
//   size          master->slave  00 byte, 01 half, 10 word, 11 reserved
//   load_unsigned master->slave  1 = zero-extend loads
//   address       master->slave  byte address
//   w_data        master->slave  right-aligned store data
//   read_data     slave->master  load result, held until next response
//   ready         slave->master  one-cycle response pulse
//   busy          slave->master  access in progress
//   err           slave->master  error flag, held until next response
// -----------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [31:0] address;
   logic [31:0] w_data;
   logic [31:0] read_data;
   logic        ready;
   logic        busy;
   logic        err;

   modport master (
      output req, we, size, load_unsigned, address, w_data,
      input  read_data, ready, busy, err
   );

   modport slave (
      input  req, we, size, load_unsigned, address, w_data,
      output read_data, ready, busy, err
   );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side endpoint of the MEM stage data-memory interface. Accepts one
// load/store at a time, inserts WAIT_CYCLES wait states, performs byte/half/
// word access with lane selection and load sign/zero extension, and returns
// the result with a one-cycle ready pulse.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, 2..65536)
//   WAIT_CYCLES  wait states between accept and response (0..15)
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   bus          dmem_responder_if.slave (request in, response out)
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses flag err, suppress the store and
//               return 0
//   undefined : misaligned accesses are silently aligned down
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input logic              clk,
   input logic              reset_n,
   dmem_responder_if.slave  bus
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;
   logic        enter_resp;

   // Latched request
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   // Response registers
   logic [31:0] read_data_q;
   logic        err_q;

   // Storage (contents not reset)
   logic [31:0] mem_q [DEPTH_WORDS];

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               accept  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

   // -------------------------------------------------------------------------
   // Access operands. With zero wait states the access happens on the same
   // edge that accepts the request, so the live inputs are used directly.
   // -------------------------------------------------------------------------
   logic        acc_we;
   logic [1:0]  acc_size;
   logic        acc_uns;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;

   assign acc_we    = accept ? bus.we            : we_q;
   assign acc_size  = accept ? bus.size          : size_q;
   assign acc_uns   = accept ? bus.load_unsigned : uns_q;
   assign acc_addr  = accept ? bus.address       : addr_q;
   assign acc_wdata = accept ? bus.w_data        : wdata_q;

   logic [AW-1:0] acc_idx;
   logic [1:0]    lane;
   logic          acc_err;
   logic          misalign;

   assign acc_idx = acc_addr[AW+1:2];
   assign lane    = acc_addr[1:0];

   // Address bits above the word index wrap and carry no meaning.
   logic unused_addr_bits;
   assign unused_addr_bits = ^acc_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = ((acc_size == 2'b01) && lane[0]) ||
                     ((acc_size == 2'b10) && (lane != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign acc_err = (acc_size == 2'b11) || misalign;

   // -------------------------------------------------------------------------
   // Store lane steering: the right-aligned store data is replicated across
   // the lanes, and the byte enables pick the aligned target bytes (half uses
   // address[1], word always lane 0).
   // -------------------------------------------------------------------------
   logic [31:0] wr_word;
   logic [3:0]  wr_be;
   logic        wr_en;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign wr_word[gi*8 +: 8] = (acc_size == 2'b00) ? acc_wdata[7:0] :
                                     (acc_size == 2'b01) ? acc_wdata[(gi%2)*8 +: 8] :
                                                           acc_wdata[gi*8 +: 8];
         assign wr_be[gi] = (acc_size == 2'b00) ? (lane == 2'(gi)) :
                            (acc_size == 2'b01) ? (lane[1] == ((gi / 2) == 1)) :
                            (acc_size == 2'b10);
      end
   endgenerate

   assign wr_en = enter_resp && acc_we && !acc_err;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem_q[acc_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Load extraction from the pre-edge word contents
   // -------------------------------------------------------------------------
   logic [31:0] mem_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;

   assign mem_word = mem_q[acc_idx];
   assign ld_byte  = 8'(mem_word >> {lane, 3'b000});
   assign ld_half  = lane[1] ? mem_word[31:16] : mem_word[15:0];

   always_comb begin
      ld_val = 32'd0;
      if (!acc_err) begin
         case (acc_size)
            2'b00:   ld_val = acc_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = acc_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            2'b10:   ld_val = mem_word;
            default: ld_val = 32'd0;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Control/response registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         read_data_q <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            uns_q   <= bus.load_unsigned;
            addr_q  <= bus.address;
            wdata_q <= bus.w_data;
         end
         if (enter_resp) begin
            read_data_q <= ld_val;
            err_q       <= acc_err;
         end
      end
   end

   assign bus.read_data = read_data_q;
   assign bus.err       = err_q;
   assign bus.ready     = (state_q == S_RESP);
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed, table-driven bench for dmem_responder (WAIT_CYCLES = 1,
// DEPTH_WORDS = 1024), plus hand-written sequences for held-request
// throughput and reset during a pending store.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int WAITC = 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   dmem_responder_if bus_if();

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        chk_rd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] erd, input logic ee, input logic cr);
      vec_t v;
      v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
      v.exp_rd = erd; v.exp_err = ee; v.chk_rd = cr;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one request starting from a negedge with the DUT idle; returns
   // the response and the accept-to-ready latency in cycles (0 = timeout).
   task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic busy_wait, output logic [33:0] after);
      bit got;
      int c;
      bus_if.req           = 1'b1;
      bus_if.we            = we;
      bus_if.size          = sz;
      bus_if.load_unsigned = uns;
      bus_if.address       = a;
      bus_if.w_data        = wd;
      @(posedge clk);
      #1;
      bus_if.req = 1'b0;
      got = 0; c = 0; lat = 0; rd = 32'd0; er = 1'b0; busy_wait = 1'b0;
      while (!got && c < 20) begin
         @(negedge clk);
         c++;
         if (c == 1) busy_wait = bus_if.busy;
         if (bus_if.ready) begin
            got = 1; lat = c; rd = bus_if.read_data; er = bus_if.err;
         end
      end
      @(negedge clk);
      after = {bus_if.ready, bus_if.busy, bus_if.read_data};
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        bw;
      logic [33:0] aft;
      int          pulses[$];
      logic [31:0] prd;
      bit          saw_ready;
      int          k;

      bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.size = 2'b00;
      bus_if.load_unsigned = 1'b0; bus_if.address = 32'd0; bus_if.w_data = 32'd0;

      // ---------------- reset state ----------------
      #1;
      check("reset_state", {29'd0, bus_if.ready, bus_if.busy, bus_if.err, bus_if.read_data},
            64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // ---------------- vector table ----------------
      //           we  size   uns  addr         wdata          exp_rd        err  chk
      vq.push_back(mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 0));
      vq.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 1));
      vq.push_back(mk(1, 2'b10, 0, 32'h10,   32'h00000000, 32'h0,        0, 0));
      vq.push_back(mk(1, 2'b00, 0, 32'h13,   32'hFFFFFF80, 32'h0,        0, 0));
      vq.push_back(mk(0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 1));
      vq.push_back(mk(0, 2'b00, 1, 32'h13,   32'h0,        32'h00000080, 0, 1));
      vq.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,        32'h80000000, 0, 1));
      vq.push_back(mk(1, 2'b10, 0, 32'h20,   32'h00000000, 32'h0,        0, 0));
      vq.push_back(mk(1, 2'b01, 0, 32'h22,   32'hABCD1234, 32'h0,        0, 0));
      vq.push_back(mk(0, 2'b01, 1, 32'h22,   32'h0,        32'h00001234, 0, 1));
      vq.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        32'h12340000, 0, 1));
      vq.push_back(mk(1, 2'b01, 0, 32'h20,   32'h00005678, 32'h0,        0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
      vq.push_back(mk(0, 2'b01, 0, 32'h21,   32'h0,        32'h00000000, 1, 1));
      vq.push_back(mk(1, 2'b01, 0, 32'h21,   32'h0000FFFF, 32'h0,        1, 0));
      vq.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        32'h12345678, 0, 1));
`else
      vq.push_back(mk(0, 2'b01, 0, 32'h21,   32'h0,        32'h00005678, 0, 1));
      vq.push_back(mk(1, 2'b01, 0, 32'h21,   32'h0000FFFF, 32'h0,        0, 0));
      vq.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        32'h1234FFFF, 0, 1));
`endif
      vq.push_back(mk(1, 2'b10, 0, 32'h30,   32'h11223344, 32'h0,        0, 0));
      vq.push_back(mk(1, 2'b11, 0, 32'h30,   32'hFFFFFFFF, 32'h0,        1, 0));
      vq.push_back(mk(0, 2'b10, 0, 32'h30,   32'h0,        32'h11223344, 0, 1));
      vq.push_back(mk(0, 2'b11, 0, 32'h30,   32'h0,        32'h00000000, 1, 1));
      vq.push_back(mk(1, 2'b00, 0, 32'h31,   32'h000000F0, 32'h0,        0, 0));
      vq.push_back(mk(0, 2'b01, 0, 32'h30,   32'h0,        32'hFFFFF044, 0, 1));
      vq.push_back(mk(0, 2'b01, 1, 32'h30,   32'h0,        32'h0000F044, 0, 1));
      vq.push_back(mk(0, 2'b00, 0, 32'h32,   32'h0,        32'h00000022, 0, 1));
      vq.push_back(mk(0, 2'b00, 1, 32'h31,   32'h0,        32'h000000F0, 0, 1));
      vq.push_back(mk(0, 2'b01, 0, 32'h32,   32'h0,        32'h00001122, 0, 1));
      vq.push_back(mk(0, 2'b10, 0, 32'h1030, 32'h0,        32'h1122F044, 0, 1));
`ifdef DMEM_MISALIGN_TRAP_EN
      vq.push_back(mk(0, 2'b10, 0, 32'h32,   32'h0,        32'h00000000, 1, 1));
`else
      vq.push_back(mk(0, 2'b10, 0, 32'h32,   32'h0,        32'h1122F044, 0, 1));
`endif

      foreach (vq[i]) begin
         access(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata,
                rd, er, lat, bw, aft);
         $display("[TB] vec %0d we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> rd=0x%08h err=%0d lat=%0d",
                  i, vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, rd, er, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(WAITC + 1));
         check($sformatf("vec%0d_busy_wait", i), 64'(bw), 64'd1);
         check($sformatf("vec%0d_err", i), 64'(er), 64'(vq[i].exp_err));
         if (vq[i].chk_rd) begin
            check($sformatf("vec%0d_read_data", i), 64'(rd), 64'(vq[i].exp_rd));
            check($sformatf("vec%0d_after", i), 64'(aft), {30'd0, 2'b00, vq[i].exp_rd});
         end else begin
            check($sformatf("vec%0d_after", i), 64'(aft[33:32]), 64'd0);
         end
      end

      // ---------------- req held high: re-accept every WAITC+2 cycles ----------------
      bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.size = 2'b10;
      bus_if.load_unsigned = 1'b0; bus_if.address = 32'h10; bus_if.w_data = 32'd0;
      pulses.delete();
      prd = 32'd0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (bus_if.ready) begin
            pulses.push_back(n);
            prd = bus_if.read_data;
         end
      end
      bus_if.req = 1'b0;
      $display("[TB] held-req: %0d pulses, last rd=0x%08h", pulses.size(), prd);
      check("held_pulse_count", 64'(pulses.size()), 64'd3);
      if (pulses.size() == 3) begin
         check("held_first_latency", 64'(pulses[0]), 64'(WAITC + 1));
         check("held_gap1", 64'(pulses[1] - pulses[0]), 64'(WAITC + 2));
         check("held_gap2", 64'(pulses[2] - pulses[1]), 64'(WAITC + 2));
      end
      check("held_read_data", 64'(prd), 64'h80000000);
      k = 0;
      while (bus_if.busy && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("held_drain", 64'(bus_if.busy), 64'd0);
      @(negedge clk);

      // ---------------- reset during WAIT of a store ----------------
      access(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, lat, bw, aft);
      $display("[TB] seed store @0x40 lat=%0d err=%0d", lat, er);
      check("seed_latency", 64'(lat), 64'(WAITC + 1));

      bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.size = 2'b10;
      bus_if.address = 32'h40; bus_if.w_data = 32'h0BADBEEF;
      @(posedge clk);
      #1;
      bus_if.req = 1'b0;
      @(negedge clk);
      check("abort_busy_in_wait", 64'(bus_if.busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("abort_reset_outputs",
            {29'd0, bus_if.ready, bus_if.busy, bus_if.err, bus_if.read_data}, 64'd0);
      saw_ready = 0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         if (bus_if.ready) saw_ready = 1;
      end
      reset_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (bus_if.ready || bus_if.busy) saw_ready = 1;
      end
      $display("[TB] abort store @0x40: ready/busy seen after reset=%0d", saw_ready);
      check("abort_no_ready", 64'(saw_ready), 64'd0);

      access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat, bw, aft);
      $display("[TB] load @0x40 after abort -> rd=0x%08h err=%0d lat=%0d", rd, er, lat);
      check("abort_prior_value", 64'(rd), 64'hCAFEF00D);
      check("abort_load_err", 64'(er), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
